// File: rtl/data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_bus_arbiter
// Purpose  : Shares the single data-memory port between the CPU MEM stage
//            and the UART DMA engine. The CPU normally wins. A DMA request
//            that stays blocked for STARVE_LIMIT consecutive cycles is
//            forced onto the bus for one cycle, and the CPU is stalled for
//            that cycle. DMA requests whose address has bit 30 set are
//            rejected with a one-cycle error pulse.
// Ports    : sysclk, reset (async, active-low)
//            cpu_rd/cpu_wr/cpu_addr/cpu_wdata -> cpu_rdata, cpu_stall
//            dma_req/dma_wr/dma_addr/dma_wdata -> dma_gnt, dma_ack,
//                                                 dma_rdata, dma_err
//            mem_addr/mem_wdata/mem_rd/mem_wr <- mem_rdata (async read)
// Revision : 1.0 - initial release
// ============================================================================
module data_bus_arbiter #(
  // Legal range 1..7, because the wait counter is 3 bits wide.
  parameter int STARVE_LIMIT = 4
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic        dma_wr,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,
  output logic        dma_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] c_limit = 3'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t     r_state;
  logic [2:0] r_wait_cnt;

  state_t     w_next_state;
  logic [2:0] w_next_cnt;
  logic [2:0] w_cnt_inc;
  logic       w_cpu_active;
  logic       w_dma_ok;
  logic       w_dma_bad;
  logic       w_cpu_gnt;
  logic       w_dma_gnt;
  logic       w_stall;

  // --------------------------------------------------------------------------
  // Arbitration decision for the current cycle
  // --------------------------------------------------------------------------
  always_comb begin
    w_cpu_active = cpu_rd | cpu_wr;
    w_dma_ok     = dma_req & ~dma_addr[30];
    w_dma_bad    = dma_req &  dma_addr[30];
    // Saturating increment: the counter stops at the limit and never wraps.
    w_cnt_inc    = (r_wait_cnt >= c_limit) ? c_limit : r_wait_cnt + 3'd1;

    w_cpu_gnt    = 1'b0;
    w_dma_gnt    = 1'b0;
    w_stall      = 1'b0;
    w_next_state = IDLE;
    w_next_cnt   = 3'd0;

    case (r_state)
      IDLE: begin
        if (w_cpu_active) begin
          w_cpu_gnt = 1'b1;
          if (w_dma_ok) begin
            // First blocked cycle; a limit of 1 starves immediately.
            w_next_cnt   = 3'd1;
            w_next_state = (3'd1 >= c_limit) ? FORCE : WAIT;
          end
        end else if (w_dma_ok) begin
          w_dma_gnt = 1'b1;
        end
      end

      WAIT: begin
        if (!w_dma_ok) begin
          // Requester gave up (or turned into a rejected address).
          w_cpu_gnt = w_cpu_active;
        end else if (w_cpu_active) begin
          w_cpu_gnt    = 1'b1;
          w_next_cnt   = w_cnt_inc;
          w_next_state = (w_cnt_inc >= c_limit) ? FORCE : WAIT;
        end else begin
          w_dma_gnt = 1'b1;
        end
      end

      FORCE: begin
        // DMA takes the port whatever the CPU wants; the CPU is frozen only
        // if it actually had an access this cycle.
        w_dma_gnt = w_dma_ok;
        w_stall   = w_dma_ok & w_cpu_active;
      end

      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Memory port steering
  // --------------------------------------------------------------------------
  always_comb begin
    dma_gnt   = w_dma_gnt;
    cpu_stall = w_stall;
    if (w_dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_wr    = dma_wr;
      mem_rd    = ~dma_wr;
      cpu_rdata = 32'd0;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wr    = w_cpu_gnt & cpu_wr;
      mem_rd    = w_cpu_gnt & cpu_rd;
      cpu_rdata = w_cpu_gnt ? mem_rdata : 32'd0;
    end
  end

  // --------------------------------------------------------------------------
  // State and registered DMA responses
  // --------------------------------------------------------------------------
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= 3'd0;
      dma_ack    <= 1'b0;
      dma_err    <= 1'b0;
      dma_rdata  <= 32'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_cnt;
      dma_ack    <= w_dma_gnt;
      dma_err    <= w_dma_bad;
      if (w_dma_gnt && !dma_wr) begin
        dma_rdata <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_bus_arbiter
// Purpose  : Randomised plus directed stimulus for data_bus_arbiter. Each
//            cycle the driver computes the expected outputs from a
//            behavioural model (blocked-cycle count, force flag, reference
//            memory) and queues them; a monitor on the falling edge pops and
//            compares against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_bus_arbiter;

  localparam int LIMIT = 4;

  logic        sysclk = 1'b0;
  logic        reset  = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dma_req = 1'b0, dma_wr = 1'b0;
  logic [31:0] dma_addr = '0, dma_wdata = '0;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_stall, dma_gnt, dma_ack, dma_err, mem_rd, mem_wr;

  data_bus_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .sysclk(sysclk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_wr(dma_wr), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_rdata(dma_rdata), .dma_err(dma_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata)
  );

  always #5 sysclk = ~sysclk;

  // Environment memory, driven only by the DUT's port.
  logic [31:0] env_mem [256];
  assign mem_rdata = env_mem[mem_addr[9:2]];
  always @(posedge sysclk) if (mem_wr) env_mem[mem_addr[9:2]] <= mem_wdata;

  typedef struct {
    int          cyc;
    logic        gnt, stall, mrd, mwr, ack, err, chk_wd;
    logic [31:0] maddr, mwdata, crdata, drdata;
  } exp_t;
  exp_t q[$];

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  // Reference model state.
  logic [31:0] ref_mem [256];
  int          m_blocked  = 0;
  bit          m_force    = 0;
  bit          m_ack      = 0, m_err = 0;
  logic [31:0] m_rdata    = '0;
  bit          prev_rst_n = 0;
  int          nb         = 0;
  bit          nf         = 0, n_ack = 0, n_err = 0, n_rd = 0, p_wr = 0;
  logic [31:0] n_rdval    = '0, p_addr = '0, p_data = '0;

  task automatic chk1(input string nm, input int cyc, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk32(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle of stimulus plus its expected response.
  task automatic cycle(input bit rst_n, input bit cr, input bit cw,
                       input logic [31:0] ca, input logic [31:0] cwd,
                       input bit dr, input bit dw,
                       input logic [31:0] da, input logic [31:0] dwd);
    exp_t e;
    bit   cpu_act, ok, gc, gd, st;
    @(posedge sysclk);
    #1;
    // Model the edge that just happened.
    if (p_wr) ref_mem[p_addr[9:2]] = p_data;
    if (prev_rst_n) begin
      m_blocked = nb;
      m_force   = nf;
      m_ack     = n_ack;
      m_err     = n_err;
      if (n_rd) m_rdata = n_rdval;
    end
    if (!rst_n) begin
      m_blocked = 0; m_force = 0; m_ack = 0; m_err = 0; m_rdata = '0;
    end
    prev_rst_n = rst_n;

    reset = rst_n; cpu_rd = cr; cpu_wr = cw; cpu_addr = ca; cpu_wdata = cwd;
    dma_req = dr; dma_wr = dw; dma_addr = da; dma_wdata = dwd;

    cpu_act = cr | cw;
    ok      = dr & ~da[30];
    gc = 0; gd = 0; st = 0;
    if (m_force) begin
      gd = ok; st = ok & cpu_act; nb = 0; nf = 0;
    end else if (cpu_act) begin
      gc = 1;
      nb = ok ? ((m_blocked + 1 > LIMIT) ? LIMIT : m_blocked + 1) : 0;
      nf = ok && (nb >= LIMIT);
    end else begin
      gd = ok; nb = 0; nf = 0;
    end

    e.cyc = cyc_n; e.gnt = gd; e.stall = st; e.chk_wd = gd | gc;
    if (gd) begin
      e.maddr = da; e.mwdata = dwd; e.mwr = dw; e.mrd = ~dw; e.crdata = '0;
    end else if (gc) begin
      e.maddr = ca; e.mwdata = cwd; e.mwr = cw; e.mrd = cr; e.crdata = ref_mem[ca[9:2]];
    end else begin
      e.maddr = ca; e.mwdata = cwd; e.mwr = 0; e.mrd = 0; e.crdata = '0;
    end
    e.ack = m_ack; e.err = m_err; e.drdata = m_rdata;
    q.push_back(e);

    n_ack = gd; n_err = dr & da[30]; n_rd = gd & ~dw; n_rdval = ref_mem[da[9:2]];
    p_wr = e.mwr; p_addr = e.maddr; p_data = e.mwdata;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectation.
  always @(negedge sysclk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk1 ("dma_gnt",   e.cyc, dma_gnt,   e.gnt);
      chk1 ("cpu_stall", e.cyc, cpu_stall, e.stall);
      chk1 ("mem_rd",    e.cyc, mem_rd,    e.mrd);
      chk1 ("mem_wr",    e.cyc, mem_wr,    e.mwr);
      chk32("mem_addr",  e.cyc, mem_addr,  e.maddr);
      if (e.chk_wd) chk32("mem_wdata", e.cyc, mem_wdata, e.mwdata);
      chk32("cpu_rdata", e.cyc, cpu_rdata, e.crdata);
      chk1 ("dma_ack",   e.cyc, dma_ack,   e.ack);
      chk1 ("dma_err",   e.cyc, dma_err,   e.err);
      chk32("dma_rdata", e.cyc, dma_rdata, e.drdata);
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 32'hDEAD0000 ^ (i * 32'h01010101);
      ref_mem[i] = 32'hDEAD0000 ^ (i * 32'h01010101);
    end
    env_mem[8] = 32'h12345678;  // address 0x20
    ref_mem[8] = 32'h12345678;

    // Reset held for a few cycles.
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);
    idle(2);

    // DMA write with CPU idle, then ack.
    cycle(1, 0, 0, 32'h0, 32'h0, 1, 1, 32'h10, 32'hA5);
    idle(2);

    // DMA read of 0x20 with CPU idle.
    cycle(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h20, 32'h0);
    idle(2);

    // CPU lw every cycle with DMA held: four CPU grants, one forced cycle.
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 32'h20, 32'h0, 1, 1, 32'h44, 32'h5A5A0000 + i);
    cycle(1, 1, 0, 32'h44, 32'h0, 0, 0, 32'h0, 32'h0);
    cycle(1, 1, 0, 32'h10, 32'h0, 0, 0, 32'h0, 32'h0);
    idle(1);

    // Rejected DMA address.
    cycle(1, 0, 0, 32'h0, 32'h0, 1, 0, 32'h40000010, 32'h0);
    idle(2);

    // Drop the request after two blocked cycles, then restart from one.
    cycle(1, 1, 0, 32'h8, 32'h0, 1, 0, 32'h20, 32'h0);
    cycle(1, 0, 1, 32'h8, 32'h77, 1, 0, 32'h20, 32'h0);
    cycle(1, 1, 0, 32'h8, 32'h0, 0, 0, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 32'h8, 32'h0, 1, 0, 32'h20, 32'h0);
    idle(2);

    // Reset asserted in the forced cycle, with both requesters still active.
    for (int i = 0; i < 4; i++) cycle(1, 1, 0, 32'h4, 32'h0, 1, 1, 32'h30, 32'hBEEF);
    cycle(0, 1, 0, 32'h4, 32'h0, 1, 1, 32'h30, 32'hBEEF);
    idle(3);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      bit          rst_n, cr, cw, dr, dw;
      int          op;
      logic [31:0] ca, da;
      rst_n = ($urandom_range(0, 299) != 0);
      op    = $urandom_range(0, 9);
      cr    = (op < 4);
      cw    = (op >= 4 && op < 7);
      dr    = ($urandom_range(0, 9) < 6);
      dw    = $urandom_range(0, 1);
      ca    = 32'($urandom_range(0, 255)) << 2;
      da    = 32'($urandom_range(0, 255)) << 2;
      if ($urandom_range(0, 15) == 0) da[30] = 1'b1;
      cycle(rst_n, cr, cw, ca, $urandom, dr, dw, da, $urandom);
    end
    idle(2);

    @(negedge sysclk);
    #1;
    chk32("queue_drained", cyc_n, 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_bus_arbiter.md
DATA_BUS_ARBITER -- requirements
Module: data_bus_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: number of consecutive blocked DMA cycles before DMA is forced onto the bus.
REQ-002 sysclk  in  1  clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low.
REQ-004 cpu_rd, cpu_wr  in  1 each  MEM-stage read / write strobes for data memory.
REQ-005 cpu_addr, cpu_wdata  in  32 each  MEM-stage address and store data.
REQ-006 cpu_rdata  out  32  data returned to MEM stage, combinational.
REQ-007 cpu_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM for the current cycle.
REQ-008 dma_req, dma_wr  in  1 each  UART DMA request; dma_wr=1 write, 0 read.
REQ-009 dma_addr, dma_wdata  in  32 each  DMA address and write data.
REQ-010 dma_gnt  out  1  DMA owns the memory port this cycle, combinational.
REQ-011 dma_ack  out  1  registered one-cycle pulse: previous-cycle DMA transfer complete.
REQ-012 dma_rdata  out  32  registered read data, valid with dma_ack.
REQ-013 dma_err  out  1  registered one-cycle pulse: rejected DMA address.
REQ-014 mem_addr, mem_wdata  out  32 each; mem_rd, mem_wr  out  1 each  port to DataMem.
REQ-015 mem_rdata  in  32  asynchronous read data from DataMem.

Function
REQ-016 cpu_active = cpu_rd | cpu_wr; dma_ok = dma_req & ~dma_addr[30].
REQ-017 FSM states: IDLE, WAIT, FORCE.
REQ-018 IDLE: cpu_active -> CPU granted; dma_ok and cpu_active -> WAIT with wait_cnt=1; dma_ok and ~cpu_active -> DMA granted, stay IDLE.
REQ-019 WAIT: cpu_active -> CPU granted, wait_cnt+1; wait_cnt reaching STARVE_LIMIT -> FORCE.
REQ-020 WAIT: ~cpu_active and dma_ok -> DMA granted, go IDLE, wait_cnt=0.
REQ-021 WAIT: dma_req deasserted -> IDLE, wait_cnt=0, no transfer.
REQ-022 FORCE: DMA granted regardless of CPU; cpu_stall=cpu_active; exactly one cycle, then IDLE with wait_cnt=0.
REQ-023 FORCE with dma_req deasserted: no grant, cpu_stall=0, go IDLE.
REQ-024 cpu_stall is 1 only in FORCE; in all other states it is 0.
REQ-025 CPU granted: mem_* = cpu_* signals, cpu_rdata=mem_rdata, dma_gnt=0.
REQ-026 DMA granted: mem_addr=dma_addr, mem_wdata=dma_wdata, mem_wr=dma_wr, mem_rd=~dma_wr, dma_gnt=1, cpu_rdata=0.
REQ-027 No grant: mem_rd=mem_wr=0, mem_addr=cpu_addr, cpu_rdata=0.
REQ-028 dma_ack=1 the cycle after every dma_gnt=1; dma_rdata latched from mem_rdata on DMA reads, held otherwise.
REQ-029 dma_req with dma_addr[30]=1: never granted; dma_err pulses the next cycle; requester must drop dma_req.
REQ-030 Back-to-back DMA grants are allowed while the CPU is idle; each grant is one word.
REQ-031 wait_cnt is 3 bits, saturates at STARVE_LIMIT, and never wraps.
REQ-032 mem_wr never asserts for both requesters in the same cycle.

Reset
REQ-033 While reset=0: state IDLE, wait_cnt=0, dma_ack=0, dma_err=0, dma_rdata=0.
REQ-034 While reset=0, combinational outputs follow IDLE rules.
REQ-035 Reset mid-FORCE aborts the transfer: no dma_ack and no memory write after release.

Verification
REQ-036 CPU idle, dma_req=1, dma_wr=1, dma_addr=0x10, dma_wdata=0xA5 -> dma_gnt=1 same cycle, mem_wr=1; dma_ack=1 next cycle.
REQ-037 CPU lw every cycle, dma_req held -> 4 CPU grants, then a FORCE cycle with cpu_stall=1 and dma_gnt=1, then CPU resumes with cpu_stall=0.
REQ-038 DMA read of addr 0x20 holding 0x12345678, CPU idle -> dma_ack=1 and dma_rdata=0x12345678 one cycle later.
REQ-039 dma_addr=0x40000010 -> dma_gnt stays 0; dma_err=1 for one cycle; no mem access.
REQ-040 dma_req dropped in WAIT after 2 blocked cycles -> IDLE; a later request restarts the count at 1.
REQ-041 reset=0 asserted during FORCE -> outputs return to reset values immediately; no dma_ack after release.
